cache_request_scheduler: RTL and testbench

Queued, fair front end for one dual-port cache bank in a router tile. It accepts access requests from the four router ports (N=0, S=1, E=2, W=3) through per-port valid/ready FIFOs. Each cycle it issues up to two requests to bank ports A and B under round-robin priority, and routes read data back to the originating port with the requester's network address. It replaces ad-hoc shared-buffer arbitration with per-port queues, backpressure and a hazard rule.

---
 rtl/cache_request_scheduler.sv | 226 ++++++++++++++++++++++
 tb/tb_cache_request_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_request_scheduler.sv
// Four-port queued front end for a dual-port cache bank: per-port FIFOs,
// round-robin dual issue with a same-address hazard rule, and read-data return.
module cache_request_scheduler #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int NET_ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [3:0]                  req_valid,
  output logic [3:0]                  req_ready,
  input  logic [3:0]                  req_write,
  input  logic [4*ADDR_WIDTH-1:0]     req_addr,
  input  logic [4*DATA_WIDTH-1:0]     req_wdata,
  input  logic [4*NET_ADDR_WIDTH-1:0] req_src,
  output logic [ADDR_WIDTH-1:0]       bank_addr_a,
  output logic [ADDR_WIDTH-1:0]       bank_addr_b,
  output logic [DATA_WIDTH-1:0]       bank_wdata_a,
  output logic [DATA_WIDTH-1:0]       bank_wdata_b,
  output logic                        bank_we_n_a,
  output logic                        bank_we_n_b,
  input  logic [DATA_WIDTH-1:0]       bank_rdata_a,
  input  logic [DATA_WIDTH-1:0]       bank_rdata_b,
  output logic [3:0]                  rsp_valid,
  output logic [4*DATA_WIDTH-1:0]     rsp_data,
  output logic [4*NET_ADDR_WIDTH-1:0] rsp_src
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH + NET_ADDR_WIDTH;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [EW-1:0] fifoMem [4][FIFO_DEPTH];
  logic [PW-1:0] wrPtr [4];
  logic [PW-1:0] rdPtr [4];
  logic [CW-1:0] count [4];
  logic [EW-1:0] pushEntry [4];
  logic [3:0]    push, pop, notEmpty;

  logic [1:0] rrPtr, nextRr;
  logic       slotValidA, slotValidB, grantB, hazard;
  logic [1:0] portA, portB;
  logic [EW-1:0] headA, headB;
  logic                      writeA, writeB;
  logic [ADDR_WIDTH-1:0]     addrA, addrB;
  logic [DATA_WIDTH-1:0]     wdataA, wdataB;
  logic [NET_ADDR_WIDTH-1:0] srcA, srcB;

  logic weNRegA, weNRegB;
  logic tag1ValidA, tag1ValidB, tag2ValidA, tag2ValidB;
  logic [1:0] tag1PortA, tag1PortB, tag2PortA, tag2PortB;
  logic [NET_ADDR_WIDTH-1:0] tag1SrcA, tag1SrcB, tag2SrcA, tag2SrcB;

  logic [3:0]                rspValidR;
  logic [DATA_WIDTH-1:0]     rspDataR [4];
  logic [NET_ADDR_WIDTH-1:0] rspSrcR  [4];

  always_comb begin
    req_ready = '0;
    push      = '0;
    notEmpty  = '0;
    for (int unsigned p = 0; p < 4; p++) begin
      req_ready[p] = !reset && (count[p] != FULL);
      push[p]      = req_valid[p] && req_ready[p];
      notEmpty[p]  = (count[p] != '0);
      pushEntry[p] = {req_write[p],
                      req_addr[p*ADDR_WIDTH +: ADDR_WIDTH],
                      req_wdata[p*DATA_WIDTH +: DATA_WIDTH],
                      req_src[p*NET_ADDR_WIDTH +: NET_ADDR_WIDTH]};
    end
  end

  // Round-robin scan: first non-empty port from rrPtr takes slot A, second takes B.
  always_comb begin
    slotValidA = 1'b0;
    slotValidB = 1'b0;
    portA      = '0;
    portB      = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (notEmpty[rrPtr + 2'(i)]) begin
        if (!slotValidA) begin
          slotValidA = 1'b1;
          portA      = rrPtr + 2'(i);
        end else if (!slotValidB) begin
          slotValidB = 1'b1;
          portB      = rrPtr + 2'(i);
        end
      end
    end
  end

  always_comb begin
    headA  = fifoMem[portA][rdPtr[portA]];
    headB  = fifoMem[portB][rdPtr[portB]];
    writeA = headA[EW-1];
    writeB = headB[EW-1];
    addrA  = headA[EW-2 -: ADDR_WIDTH];
    addrB  = headB[EW-2 -: ADDR_WIDTH];
    wdataA = headA[DATA_WIDTH+NET_ADDR_WIDTH-1 -: DATA_WIDTH];
    wdataB = headB[DATA_WIDTH+NET_ADDR_WIDTH-1 -: DATA_WIDTH];
    srcA   = headA[NET_ADDR_WIDTH-1:0];
    srcB   = headB[NET_ADDR_WIDTH-1:0];
    hazard = slotValidA && slotValidB && (addrA == addrB) && (writeA || writeB);
    grantB = slotValidB && !hazard;
    pop    = '0;
    if (slotValidA) pop[portA] = 1'b1;
    if (grantB)     pop[portB] = 1'b1;
    if (grantB)          nextRr = portB + 2'd1;
    else if (slotValidA) nextRr = portA + 2'd1;
    else                 nextRr = rrPtr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rrPtr <= '0;
      for (int unsigned p = 0; p < 4; p++) begin
        wrPtr[p] <= '0;
        rdPtr[p] <= '0;
        count[p] <= '0;
      end
    end else begin
      rrPtr <= nextRr;
      for (int unsigned p = 0; p < 4; p++) begin
        if (push[p]) wrPtr[p] <= wrPtr[p] + 1'b1;
        if (pop[p])  rdPtr[p] <= rdPtr[p] + 1'b1;
        count[p] <= count[p] + CW'(push[p]) - CW'(pop[p]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < 4; p++) begin
      if (push[p]) fifoMem[p][wrPtr[p]] <= pushEntry[p];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !slotValidA) begin
      bank_addr_a  <= '0;
      bank_wdata_a <= '0;
      weNRegA      <= 1'b1;
    end else begin
      bank_addr_a  <= addrA;
      bank_wdata_a <= wdataA;
      weNRegA      <= !writeA;
    end
    if (reset || !grantB) begin
      bank_addr_b  <= '0;
      bank_wdata_b <= '0;
      weNRegB      <= 1'b1;
    end else begin
      bank_addr_b  <= addrB;
      bank_wdata_b <= wdataB;
      weNRegB      <= !writeB;
    end
  end

  // Reset must cancel a write already sitting on the bank outputs in the same cycle.
  assign bank_we_n_a = weNRegA | reset;
  assign bank_we_n_b = weNRegB | reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      tag1ValidA <= 1'b0;
      tag1ValidB <= 1'b0;
      tag2ValidA <= 1'b0;
      tag2ValidB <= 1'b0;
      tag1PortA  <= '0;
      tag1PortB  <= '0;
      tag2PortA  <= '0;
      tag2PortB  <= '0;
      tag1SrcA   <= '0;
      tag1SrcB   <= '0;
      tag2SrcA   <= '0;
      tag2SrcB   <= '0;
    end else begin
      tag1ValidA <= slotValidA && !writeA;
      tag1ValidB <= grantB && !writeB;
      tag1PortA  <= portA;
      tag1PortB  <= portB;
      tag1SrcA   <= srcA;
      tag1SrcB   <= srcB;
      tag2ValidA <= tag1ValidA;
      tag2ValidB <= tag1ValidB;
      tag2PortA  <= tag1PortA;
      tag2PortB  <= tag1PortB;
      tag2SrcA   <= tag1SrcA;
      tag2SrcB   <= tag1SrcB;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rspValidR <= '0;
      for (int unsigned p = 0; p < 4; p++) begin
        rspDataR[p] <= '0;
        rspSrcR[p]  <= '0;
      end
    end else begin
      rspValidR <= '0;
      if (tag2ValidA) begin
        rspValidR[tag2PortA] <= 1'b1;
        rspDataR[tag2PortA]  <= bank_rdata_a;
        rspSrcR[tag2PortA]   <= tag2SrcA;
      end
      if (tag2ValidB) begin
        rspValidR[tag2PortB] <= 1'b1;
        rspDataR[tag2PortB]  <= bank_rdata_b;
        rspSrcR[tag2PortB]   <= tag2SrcB;
      end
    end
  end

  always_comb begin
    rsp_valid = rspValidR;
    rsp_data  = '0;
    rsp_src   = '0;
    for (int unsigned p = 0; p < 4; p++) begin
      rsp_data[p*DATA_WIDTH +: DATA_WIDTH]        = rspDataR[p];
      rsp_src[p*NET_ADDR_WIDTH +: NET_ADDR_WIDTH] = rspSrcR[p];
    end
  end

endmodule

// File: tb/tb_cache_request_scheduler.sv
// Directed bench for cache_request_scheduler with a synchronous dual-port RAM model
// and a per-port in-order response scoreboard.
module tb_cache_request_scheduler;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [3:0]   req_write = '0;
  logic [31:0]  req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic [15:0]  req_src = '0;
  logic [7:0]   bank_addr_a, bank_addr_b;
  logic [31:0]  bank_wdata_a, bank_wdata_b;
  logic         bank_we_n_a, bank_we_n_b;
  logic [31:0]  bank_rdata_a, bank_rdata_b;
  logic [3:0]   rsp_valid;
  logic [127:0] rsp_data;
  logic [15:0]  rsp_src;

  cache_request_scheduler #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .NET_ADDR_WIDTH(4), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_src(req_src),
    .bank_addr_a(bank_addr_a), .bank_addr_b(bank_addr_b),
    .bank_wdata_a(bank_wdata_a), .bank_wdata_b(bank_wdata_b),
    .bank_we_n_a(bank_we_n_a), .bank_we_n_b(bank_we_n_b),
    .bank_rdata_a(bank_rdata_a), .bank_rdata_b(bank_rdata_b),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_src(rsp_src)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int monIdx;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] initVal(logic [7:0] a);
    return {8'hC0, a, 8'h5A, ~a};
  endfunction

  // Bank RAM: contents restored to a known pattern while reset is high.
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) ram[i] <= initVal(8'(i));
      ram[8'h15] <= 32'hCAFE0001;
    end else begin
      if (!bank_we_n_a) ram[bank_addr_a] <= bank_wdata_a;
      if (!bank_we_n_b) ram[bank_addr_b] <= bank_wdata_b;
    end
    bank_rdata_a <= ram[bank_addr_a];
    bank_rdata_b <= ram[bank_addr_b];
  end

  typedef struct {
    int          port;
    logic [31:0] data;
    logic [3:0]  src;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response pulse must match the oldest pending entry for its port.
  always @(negedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (rsp_valid[p]) begin
        monIdx = -1;
        for (int i = 0; i < sbq.size(); i++)
          if (monIdx < 0 && sbq[i].port == p) monIdx = i;
        if (monIdx < 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected port=%0d actual data=%h src=%h required no response (cycle %0d)",
                   p, rsp_data[p*32 +: 32], rsp_src[p*4 +: 4], cyc);
        end else begin
          chk($sformatf("rsp_port%0d_data_src", p), {28'h0, rsp_data[p*32 +: 32], rsp_src[p*4 +: 4]},
              {28'h0, sbq[monIdx].data, sbq[monIdx].src});
          if (sbq[monIdx].cyc >= 0)
            chk($sformatf("rsp_port%0d_cycle", p), 64'(cyc), 64'(sbq[monIdx].cyc));
          sbq.delete(monIdx);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic atNeg(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  task automatic setReq(input int p, input logic w, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    req_valid[p]        = 1'b1;
    req_write[p]        = w;
    req_addr[p*8 +: 8]   = a;
    req_wdata[p*32 +: 32] = d;
    req_src[p*4 +: 4]    = s;
  endtask

  task automatic clearReq();
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_src   = '0;
  endtask

  task automatic expRsp(input int p, input logic [31:0] d, input logic [3:0] s, input int c);
    sbq.push_back('{port: p, data: d, src: s, cyc: c});
  endtask

  task automatic doReset();
    reset = 1'b1;
    clearReq();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && sbq.size() > 0; i++) tick();
    tick();
    tick();
    chk(name, 64'(sbq.size()), 64'd0);
    sbq.delete();
  endtask

  int hs;
  int k [4];
  logic [3:0] expReady;

  initial begin
    // Reset state
    tick();
    @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'h0);
    chk("reset_we_n", {62'h0, bank_we_n_a, bank_we_n_b}, 64'h3);
    chk("reset_bank_addr", {48'h0, bank_addr_a, bank_addr_b}, 64'h0);
    chk("reset_bank_wdata", {bank_wdata_a, bank_wdata_b}, 64'h0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(req_ready), 64'hF);
    tick();

    // Single read, port 2
    hs = cyc;
    setReq(2, 1'b0, 8'h15, 32'h0, 4'h9);
    expRsp(2, 32'hCAFE0001, 4'h9, hs + 4);
    tick();
    clearReq();
    drain("single_read_drain");

    // Four-way write contention from rr_ptr = 0
    doReset();
    hs = cyc;
    for (int p = 0; p < 4; p++) setReq(p, 1'b1, 8'(8'h40 + p), 32'hA000_0000 + 32'(p), 4'(p));
    tick();
    clearReq();
    atNeg(hs + 2);
    chk("fourway_c2_addr", {48'h0, bank_addr_a, bank_addr_b}, 64'h4041);
    chk("fourway_c2_we_n", {62'h0, bank_we_n_a, bank_we_n_b}, 64'h0);
    chk("fourway_c2_wdata", {bank_wdata_a, bank_wdata_b}, 64'hA0000000_A0000001);
    atNeg(hs + 3);
    chk("fourway_c3_addr", {48'h0, bank_addr_a, bank_addr_b}, 64'h4243);
    chk("fourway_c3_we_n", {62'h0, bank_we_n_a, bank_we_n_b}, 64'h0);
    atNeg(hs + 4);
    chk("fourway_c4_idle", {62'h0, bank_we_n_a, bank_we_n_b}, 64'h3);
    tick();
    // Read back; rr_ptr back at 0 puts port 0 on slot A
    hs = cyc;
    setReq(0, 1'b0, 8'h40, 32'h0, 4'h1);
    setReq(1, 1'b0, 8'h42, 32'h0, 4'h2);
    expRsp(0, 32'hA000_0000, 4'h1, hs + 4);
    expRsp(1, 32'hA000_0002, 4'h2, hs + 4);
    tick();
    clearReq();
    atNeg(hs + 2);
    chk("readback_slot_addr", {48'h0, bank_addr_a, bank_addr_b}, 64'h4042);
    drain("fourway_drain");

    // Hazard: port 0 write and port 1 read of 0x20 in one cycle
    doReset();
    hs = cyc;
    setReq(0, 1'b1, 8'h20, 32'h55, 4'h3);
    setReq(1, 1'b0, 8'h20, 32'h0, 4'hB);
    expRsp(1, 32'h55, 4'hB, hs + 5);
    tick();
    clearReq();
    atNeg(hs + 2);
    chk("hazard_c2_a", {55'h0, bank_we_n_a, bank_addr_a}, {55'h0, 1'b0, 8'h20});
    chk("hazard_c2_b_idle", {55'h0, bank_we_n_b, bank_addr_b}, {55'h0, 1'b1, 8'h00});
    atNeg(hs + 3);
    chk("hazard_c3_a", {55'h0, bank_we_n_a, bank_addr_a}, {55'h0, 1'b1, 8'h20});
    drain("hazard_drain");

    // Backpressure: all ports hold reads; ready pattern derived by hand from +1/2 per cycle
    doReset();
    hs = cyc;
    for (int p = 0; p < 4; p++) k[p] = 0;
    for (int c = 0; c < 20; c++) begin
      for (int p = 0; p < 4; p++)
        setReq(p, 1'b0, 8'(8'h80 + p*32 + k[p]), 32'h0, 4'(p*4 + k[p]));
      atNeg(hs + c);
      if (c < 14)          expReady = 4'b1111;
      else if (c % 2 == 0) expReady = 4'b0011;
      else                 expReady = 4'b1100;
      chk($sformatf("backpressure_ready_c%0d", c), 64'(req_ready), 64'(expReady));
      for (int p = 0; p < 4; p++) begin
        if (req_ready[p]) begin
          expRsp(p, initVal(8'(8'h80 + p*32 + k[p])), 4'(p*4 + k[p]), -1);
          k[p]++;
        end
      end
      tick();
    end
    clearReq();
    drain("backpressure_drain");

    // Fairness: ports 0 and 3 continuously valid
    doReset();
    hs = cyc;
    for (int j = 0; j < 8; j++) begin
      if (j < 6) begin
        setReq(0, 1'b0, 8'(8'h60 + j), 32'h0, 4'(j));
        setReq(3, 1'b0, 8'(8'h70 + j), 32'h0, 4'(j + 8));
        expRsp(0, initVal(8'(8'h60 + j)), 4'(j), hs + j + 4);
        expRsp(3, initVal(8'(8'h70 + j)), 4'(j + 8), hs + j + 4);
      end else begin
        clearReq();
      end
      atNeg(hs + j);
      if (j >= 2)
        chk($sformatf("fair_slots_c%0d", j), {48'h0, bank_addr_a, bank_addr_b},
            {48'h0, 8'(8'h60 + j - 2), 8'(8'h70 + j - 2)});
      tick();
    end
    clearReq();
    drain("fairness_drain");

    // Reset in cycle 2 of a port 1 read
    hs = cyc;
    setReq(1, 1'b0, 8'h16, 32'h0, 4'h7);
    tick();
    clearReq();
    tick();
    reset = 1'b1;
    atNeg(hs + 2);
    chk("midreset_ready_low", 64'(req_ready), 64'h0);
    tick();
    reset = 1'b0;
    atNeg(hs + 3);
    chk("midreset_ready_high", 64'(req_ready), 64'hF);
    chk("midreset_we_n", {62'h0, bank_we_n_a, bank_we_n_b}, 64'h3);
    chk("midreset_bank_addr", {48'h0, bank_addr_a, bank_addr_b}, 64'h0);
    chk("midreset_bank_wdata", {bank_wdata_a, bank_wdata_b}, 64'h0);
    chk("midreset_rsp_data_lo", rsp_data[63:0], 64'h0);
    chk("midreset_rsp_data_hi", rsp_data[127:64], 64'h0);
    chk("midreset_rsp_src", 64'(rsp_src), 64'h0);
    for (int n = 3; n <= 6; n++) begin
      if (n > 3) atNeg(hs + n);
      chk($sformatf("midreset_no_rsp_c%0d", n), 64'(rsp_valid), 64'h0);
    end
    drain("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
